// File: rtl/nco_mixer_param.sv
// Phase-accumulator NCO with sin/cos ROM and a complex mixer, fixed 4-cycle latency.
// Mode bits ride down the pipeline with their sample so they can change on any accepted sample.
module nco_mixer_param #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 8,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PHASE_W-1:0]       delta_index_i,
    input  logic                     phase_clr_i,
    input  logic                     conj_i,
    input  logic                     bypass_i,
    input  logic signed [DATA_W-1:0] real_i,
    input  logic signed [DATA_W-1:0] imag_i,
    input  logic                     valid_i,
    output logic signed [OUT_W-1:0]  real_o,
    output logic signed [OUT_W-1:0]  imag_o,
    output logic                     valid_o,
    output logic                     sat_o
);
    localparam int STAGES = 4;
    localparam int LUT_N  = 1 << LUT_ADDR_W;
    localparam int PW     = 2 * DATA_W;
    localparam int SW     = PW + 1;
    localparam int EW     = ((SW > OUT_W) ? SW : OUT_W) + 1;
    localparam logic signed [SW-1:0] RND  = SW'(64'sd1 <<< (DATA_W - 2));
    localparam logic signed [EW-1:0] OMAX = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] OMIN = -OMAX - EW'(1);

    // ROM contents are elaboration-time constants; the casts round half away from zero.
    function automatic logic signed [DATA_W-1:0] lut_entry(input int k, input bit is_sin);
        real a, x;
        a = real'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
        x = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N);
        x = a * (is_sin ? $sin(x) : $cos(x));
        return DATA_W'(int'(x));
    endfunction

    // Returns {clip, value}.
    function automatic logic [OUT_W:0] scale_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        logic signed [EW-1:0] e;
        r = (v + RND) >>> (DATA_W - 1);
        e = EW'(r);
        if (e > OMAX) return {1'b1, OMAX[OUT_W-1:0]};
        if (e < OMIN) return {1'b1, OMIN[OUT_W-1:0]};
        return {1'b0, e[OUT_W-1:0]};
    endfunction

    logic signed [DATA_W-1:0] cos_tab [LUT_N];
    logic signed [DATA_W-1:0] sin_tab [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign cos_tab[k] = lut_entry(k, 1'b0);
        assign sin_tab[k] = lut_entry(k, 1'b1);
    end

    logic [PHASE_W-1:0]       acc, phase_use;
    logic [STAGES:1]          vld_pipe;
    logic signed [DATA_W-1:0] xr1, xi1, xr2, xi2, xr3, xi3, c2, s2;
    logic [LUT_ADDR_W-1:0]    addr1;
    logic                     conj1, conj2, conj3, byp1, byp2, byp3;
    logic signed [PW-1:0]     p_rc, p_is, p_rs, p_ic;
    logic signed [SW-1:0]     sum_re, sum_im;
    logic [OUT_W:0]           re_res, im_res;

    assign phase_use = phase_clr_i ? '0 : acc;
    assign valid_o   = vld_pipe[STAGES];

    always_comb begin
        sum_re = conj3 ? SW'(p_rc) + SW'(p_is) : SW'(p_rc) - SW'(p_is);
        sum_im = conj3 ? SW'(p_ic) - SW'(p_rs) : SW'(p_rs) + SW'(p_ic);
        re_res = scale_sat(sum_re);
        im_res = scale_sat(sum_im);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            vld_pipe <= '0;
            xr1 <= '0; xi1 <= '0; addr1 <= '0; conj1 <= 1'b0; byp1 <= 1'b0;
            xr2 <= '0; xi2 <= '0; c2 <= '0; s2 <= '0; conj2 <= 1'b0; byp2 <= 1'b0;
            xr3 <= '0; xi3 <= '0; conj3 <= 1'b0; byp3 <= 1'b0;
            p_rc <= '0; p_is <= '0; p_rs <= '0; p_ic <= '0;
            real_o <= '0; imag_o <= '0; sat_o <= 1'b0;
        end else begin
            if (valid_i)          acc <= phase_use + delta_index_i;
            else if (phase_clr_i) acc <= '0;
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
            // S1: capture sample, mode and table address
            xr1   <= real_i;
            xi1   <= imag_i;
            conj1 <= conj_i;
            byp1  <= bypass_i;
            addr1 <= phase_use[PHASE_W-1 -: LUT_ADDR_W];
            // S2: ROM read
            xr2   <= xr1;
            xi2   <= xi1;
            conj2 <= conj1;
            byp2  <= byp1;
            c2    <= cos_tab[addr1];
            s2    <= sin_tab[addr1];
            // S3: products
            xr3   <= xr2;
            xi3   <= xi2;
            conj3 <= conj2;
            byp3  <= byp2;
            p_rc  <= PW'(xr2) * PW'(c2);
            p_is  <= PW'(xi2) * PW'(s2);
            p_rs  <= PW'(xr2) * PW'(s2);
            p_ic  <= PW'(xi2) * PW'(c2);
            // S4: outputs only move on valid samples so they hold through bubbles
            if (vld_pipe[3]) begin
                real_o <= byp3 ? OUT_W'(xr3) : re_res[OUT_W-1:0];
                imag_o <= byp3 ? OUT_W'(xi3) : im_res[OUT_W-1:0];
                sat_o  <= byp3 ? 1'b0 : (re_res[OUT_W] | im_res[OUT_W]);
            end
        end
    end
endmodule

// File: tb/tb_nco_mixer_param.sv
// Bench for nco_mixer_param: real-arithmetic model with a per-cycle compare, plus literal vectors.
module tb_nco_mixer_param;
    logic              clk = 1'b0, rst = 1'b0;
    logic [31:0]       delta = '0;
    logic              clr = 1'b0, conj = 1'b0, byp = 1'b0, vin = 1'b0;
    logic signed [7:0] rin = '0, iin = '0;
    logic signed [7:0] real_o, imag_o;
    logic              valid_o, sat_o;

    int n_cmp = 0, n_fail = 0;

    typedef struct {bit v; int re; int im; bit sat;} exp_t;
    exp_t            mpipe [4];
    exp_t            held;
    longint unsigned mph;
    int              got_re[$], got_im[$], got_sat[$];

    nco_mixer_param #(.DATA_W(8), .OUT_W(8), .PHASE_W(32), .LUT_ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .delta_index_i(delta), .phase_clr_i(clr), .conj_i(conj),
        .bypass_i(byp), .real_i(rin), .imag_i(iin), .valid_i(vin),
        .real_o(real_o), .imag_o(imag_o), .valid_o(valid_o), .sat_o(sat_o));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lut(input int k, input bit is_sin);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / 256.0;
        return int'(127.0 * (is_sin ? $sin(ang) : $cos(ang)));
    endfunction

    function automatic int clamp(input int y);
        return (y > 127) ? 127 : ((y < -128) ? -128 : y);
    endfunction

    function automatic exp_t model(input int xr, input int xi, input bit cj, input bit bp,
                                   input longint unsigned ph);
        exp_t e;
        int k, c, s, sr, si, yr, yi;
        e.v = 1'b1;
        if (bp) begin
            e.re = xr; e.im = xi; e.sat = 1'b0;
            return e;
        end
        k  = int'(ph >> 24);
        c  = lut(k, 1'b0);
        s  = lut(k, 1'b1);
        sr = cj ? xr * c + xi * s : xr * c - xi * s;
        si = cj ? xi * c - xr * s : xr * s + xi * c;
        yr = int'($floor(real'(sr + 64) / 128.0));
        yi = int'($floor(real'(si + 64) / 128.0));
        e.sat = (yr != clamp(yr)) || (yi != clamp(yi));
        e.re  = clamp(yr);
        e.im  = clamp(yi);
        return e;
    endfunction

    // Model: decides each accepted sample's phase and expected output, delayed 4 cycles.
    always @(posedge clk or negedge rst) begin : model_p
        exp_t e;
        longint unsigned use_ph;
        if (!rst) begin
            for (int i = 0; i < 4; i++) mpipe[i] <= '{1'b0, 0, 0, 1'b0};
            mph <= 0;
        end else begin
            e = '{1'b0, 0, 0, 1'b0};
            use_ph = clr ? 64'd0 : mph;
            if (vin) begin
                e = model(rin, iin, conj, byp, use_ph);
                mph <= (use_ph + 64'(delta)) & 64'hFFFF_FFFF;
            end else if (clr) begin
                mph <= 0;
            end
            mpipe[3] <= mpipe[2];
            mpipe[2] <= mpipe[1];
            mpipe[1] <= mpipe[0];
            mpipe[0] <= e;
        end
    end

    always @(negedge clk) begin : compare_p
        if (!rst) begin
            held = '{1'b0, 0, 0, 1'b0};
            chk("reset valid_o", valid_o, 0);
            chk("reset real_o", real_o, 0);
            chk("reset imag_o", imag_o, 0);
            chk("reset sat_o", sat_o, 0);
        end else begin
            if (mpipe[3].v) held = mpipe[3];
            chk("valid_o", valid_o, int'(mpipe[3].v));
            chk("real_o", real_o, held.re);
            chk("imag_o", imag_o, held.im);
            chk("sat_o", sat_o, int'(held.sat));
            if (valid_o) begin
                got_re.push_back(real_o);
                got_im.push_back(imag_o);
                got_sat.push_back(int'(sat_o));
            end
        end
    end

    task automatic drive(input bit v, input int r, input int i, input logic [31:0] d,
                         input bit c, input bit b, input bit cl);
        vin = v; rin = 8'(r); iin = 8'(i); delta = d; conj = c; byp = b; clr = cl;
        @(posedge clk); #1;
        vin = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_out(input string nm, input int idx, input int re, input int im, input int sat);
        if (idx < got_re.size()) begin
            chk({nm, " re"}, got_re[idx], re);
            chk({nm, " im"}, got_im[idx], im);
            chk({nm, " sat"}, got_sat[idx], sat);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: output %0d missing, only %0d seen", nm, idx, got_re.size());
        end
    endtask

    localparam logic [31:0] Q  = 32'h4000_0000;
    localparam logic [31:0] E8 = 32'h2000_0000;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        idle(3);
        rst = 1'b1;
        idle(2);

        // DC input at phase 0
        base = got_re.size();
        drive(1, 100, 0, 32'd0, 0, 0, 1);
        idle(6);
        chk_out("dc0", base, 99, 0, 0);

        // quarter-turn rotation, then its conjugate
        for (int m = 0; m < 2; m++) begin
            base = got_re.size();
            for (int n = 0; n < 4; n++) drive(1, 64, 0, Q, bit'(m), 0, n == 0);
            idle(6);
            chk_out(m ? "cj0" : "rot0", base,   64, 0, 0);
            chk_out(m ? "cj1" : "rot1", base+1, 0, m ? -63 : 64, 0);
            chk_out(m ? "cj2" : "rot2", base+2, -63, 0, 0);
            chk_out(m ? "cj3" : "rot3", base+3, 0, m ? 64 : -63, 0);
        end

        // reset with samples in flight
        for (int n = 0; n < 3; n++) drive(1, 64, 0, Q, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("async rst valid_o", valid_o, 0);
        chk("async rst real_o", real_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        base = got_re.size();
        idle(6);
        chk("no stale outputs", got_re.size() - base, 0);
        drive(1, 64, 0, Q, 0, 0, 0);
        drive(1, 64, 0, Q, 0, 0, 0);
        idle(6);
        chk_out("post-rst ph0", base, 64, 0, 0);
        chk_out("post-rst ph90", base+1, 0, 64, 0);

        // saturation at 45 degrees
        base = got_re.size();
        drive(1, 0, 0, E8, 0, 0, 1);
        drive(1, -128, -128, 32'd0, 0, 0, 0);
        idle(6);
        chk_out("sat45", base+1, 0, -128, 1);

        // bubbles
        base = got_re.size();
        drive(1, 64, 0, Q, 0, 0, 1);
        drive(0, 0, 0, Q, 0, 0, 0);
        drive(1, 64, 0, Q, 0, 0, 0);
        drive(1, 64, 0, Q, 0, 0, 0);
        idle(6);
        chk("bubble count", got_re.size() - base, 3);
        chk_out("bub0", base, 64, 0, 0);
        chk_out("bub90", base+1, 0, 64, 0);
        chk_out("bub180", base+2, -63, 0, 0);

        // clear mid-stream, bypass keeps the phase running
        base = got_re.size();
        for (int n = 0; n < 3; n++) drive(1, 64, 0, Q, 0, 0, n == 0);
        drive(1, 64, 0, Q, 0, 0, 1);
        drive(1, 64, 0, Q, 0, 0, 0);
        drive(1, -128, 127, Q, 0, 1, 0);
        drive(1, 64, 0, Q, 0, 0, 0);
        idle(6);
        chk_out("clr ph0", base+3, 64, 0, 0);
        chk_out("clr ph90", base+4, 0, 64, 0);
        chk_out("bypass", base+5, -128, 127, 0);
        chk_out("after bypass", base+6, 0, -63, 0);

        // random mix of modes, bubbles and clears against the model
        for (int n = 0; n < 80; n++)
            drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, $urandom, bit'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
